vga_plot_arbiter: RTL

- Shares the single VGA framebuffer write port (plot/x/y/colour) between several sprite controllers, such as the cursor/draw controllers.
- Each requester asks for a SIZE×SIZE square at a base coordinate, in a given colour. Erasing is a draw in the background colour.
- The block arbitrates round-robin, walks the square in raster order at one pixel per clock, and clips to the 160×120 screen.

---
 rtl/vga_plot_arbiter_if.sv | 27 ++
 rtl/vga_plot_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter_if.sv
// Request/plot bundle between the sprite controllers and the framebuffer plot arbiter.
// The master side is the requester bank; the slave side is the arbiter.
interface vga_plot_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_x;
  logic [7*NREQ-1:0] req_y;
  logic [3*NREQ-1:0] req_colour;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              done;
  logic              plot;
  logic [7:0]        x_out;
  logic [6:0]        y_out;
  logic [2:0]        colour_out;

  modport master (
    output req, req_x, req_y, req_colour,
    input  grant, busy, done, plot, x_out, y_out, colour_out
  );

  modport slave (
    input  req, req_x, req_y, req_colour,
    output grant, busy, done, plot, x_out, y_out, colour_out
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the framebuffer write port; walks a SIZE x SIZE square
// in raster order at one pixel per clock, clipping pixels outside the screen.
module vga_plot_arbiter #(
  parameter int NREQ = 4,
  parameter int SIZE = 4,
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic              clock,
  input  logic              reset_n,
  vga_plot_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  localparam logic [PW:0]   NR   = (PW + 1)'(NREQ);
  localparam logic [PW-1:0] TOP  = PW'(NREQ - 1);
  localparam logic [8:0]    XLIM = 9'(XMAX);
  localparam logic [8:0]    YLIM = 9'(YMAX);

  typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic [PW-1:0]   rr_q, rr_d, win_q, win_d;
  logic [7:0]      bx_q, bx_d;
  logic [6:0]      by_q, by_d;
  logic [2:0]      bc_q, bc_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            done_q, done_d;

  logic            found;
  logic [PW-1:0]   pick;
  logic [PW:0]     sum;
  logic [PW-1:0]   idx;
  logic [7:0]      pick_x;
  logic [6:0]      pick_y;
  logic [2:0]      pick_c;

  // Search starts at rr_q and wraps; rr_q < NREQ so one subtraction suffices.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_q} + (PW + 1)'(i);
      if (sum >= NR) sum = sum - NR;
      idx = sum[PW-1:0];
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    pick_x = '0;
    pick_y = '0;
    pick_c = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (PW'(j) == pick) begin
        pick_x = bus.req_x[8*j +: 8];
        pick_y = bus.req_y[7*j +: 7];
        pick_c = bus.req_colour[3*j +: 3];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    rr_d    = rr_q;
    win_d   = win_q;
    bx_d    = bx_q;
    by_d    = by_q;
    bc_d    = bc_q;
    grant_d = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          bx_d    = pick_x;
          by_d    = pick_y;
          bc_d    = pick_c;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          dx_d    = '0;
          dy_d    = '0;
          state_d = PLOT;
        end
      end
      PLOT: begin
        if (dx_q == LAST && dy_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (dx_q == LAST) begin
          dx_d = '0;
          dy_d = dy_q + 1'b1;
        end else begin
          dx_d = dx_q + 1'b1;
        end
      end
      DONE: begin
        rr_d    = (win_q == TOP) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      rr_q    <= '0;
      win_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      bc_q    <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bc_q    <= bc_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  logic       in_plot;
  logic [8:0] px, py;

  assign in_plot = (state_q == PLOT);
  assign px      = {1'b0, bx_q} + {{(9-CW){1'b0}}, dx_q};
  assign py      = {2'b0, by_q} + {{(9-CW){1'b0}}, dy_q};

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.plot       = in_plot && (px < XLIM) && (py < YLIM);
  assign bus.x_out      = in_plot ? px[7:0] : 8'd0;
  assign bus.y_out      = in_plot ? py[6:0] : 7'd0;
  assign bus.colour_out = in_plot ? bc_q : 3'd0;
endmodule
